wb_stage_reg: RTL and testbench
===============================

Name: wb_stage_reg

Overview:
Parametrised MEM/WB pipeline register. Next generation of the single-lane stage register, for the multi-issue MIPS pipeline.
- Carries NUM_LANES register-file write-back lanes plus one HI/LO write, with a valid bit per stage slot.
- Handles clear, flush, stall-bubble and stall-hold.
- Resolves same-address write collisions between lanes.
- Keeps a retired-instruction counter.
- Sits between the MEM stage and the register file / HI-LO unit.

Parameters:
NUM_LANES, 2, number of parallel write-back lanes (1..4)
ADDR_W, 5, register address width
DATA_W, 32, register data width
STAGE, 4, index of this stage's bit in the stall vector; must be 0..4
CNT_W, 32, retire counter width

Ports:
clk  in  1  clock, rising edge
clr  in  1  synchronous active-high reset/clear
stall  in  6  pipeline stall vector from the stall controller
flush  in  1  exception/branch flush; turns this cycle's capture into a bubble
mem_valid  in  1  MEM slot holds a real instruction group
mem_wd  in  NUM_LANES*ADDR_W  per-lane destination address, lane i at [i*ADDR_W +: ADDR_W]
mem_wreg  in  NUM_LANES  per-lane write enable
mem_wdata  in  NUM_LANES*DATA_W  per-lane write data
mem_hi  in  DATA_W  HI value
mem_lo  in  DATA_W  LO value
mem_whilo  in  1  HI/LO write enable
wb_valid  out  1  WB slot valid
wb_wd  out  NUM_LANES*ADDR_W  registered destination addresses
wb_wreg  out  NUM_LANES  registered, collision-resolved write enables
wb_wdata  out  NUM_LANES*DATA_W  registered write data
wb_hi  out  DATA_W  registered HI
wb_lo  out  DATA_W  registered LO
wb_whilo  out  1  registered HI/LO enable
retired  out  CNT_W  count of valid groups that advanced into WB

Behaviour:
- All state updates on rising clk. No combinational path from inputs to outputs, except the optional forwarding ports.
- Update priority per cycle, highest first:
  1. clr: every output goes to 0, including retired. wb_wd = 0 (NOP address); all enables and valid = 0.
  2. flush: bubble. wb_valid, wb_wreg and wb_whilo go to 0; wb_wd, wb_wdata, wb_hi and wb_lo go to 0. retired holds.
  3. stall[STAGE]=1 and stall[STAGE+1]=0: bubble, same values as flush.
  4. stall[STAGE]=0: advance.
     - Capture all mem_* fields.
     - wb_valid <= mem_valid.
     - Enables are qualified: wb_wreg[i] <= mem_wreg[i] & mem_valid; wb_whilo <= mem_whilo & mem_valid.
  5. stall[STAGE]=1 and stall[STAGE+1]=1: hold. All outputs unchanged.
- Latency: 1 cycle from MEM to WB on advance.
- Collision rule, applied at capture:
  - If lanes i<j both have wreg=1 with equal wd, then wb_wreg[i] is forced to 0. The highest-numbered lane wins (program order).
  - A write to address 0 is kept as-is; the register file ignores it.
- retired increments by 1 on each advance with mem_valid=1. It wraps modulo 2^CNT_W, with no saturation.
- Reset mid-stall: clr wins; the next cycle behaves per the stall vector.
- With NUM_LANES=1, behaviour equals the single-lane stage register plus valid gating and the counter.

Optional Feature:
Macro WB_FWD_EN.
- Defined: adds ports fwd_raddr (in, 2*ADDR_W, two read addresses), fwd_hit (out, 2) and fwd_data (out, 2*DATA_W).
  - Combinational lookup against the registered wb_* outputs.
  - For each read port: hit if some lane has wb_wreg=1, wb_wd equal to the read address, and the address is nonzero.
  - Highest matching lane supplies fwd_data.
  - On a miss, fwd_data is 0.
- Undefined: those ports and their logic are absent; the remaining behaviour is unchanged.

Decomposition:
- Shared package/defines: NOP register address, write enable/disable constants, stall vector width (6), default ADDR_W and DATA_W.
- One natural sub-module: wb_collide_mask.
  - Purely combinational.
  - Inputs: NUM_LANES addresses and enables.
  - Output: the masked enables.
  - Reused by the forwarding lookup's priority select.

Test Plan:
1. clr=1 while advancing valid data → next cycle all outputs 0, retired=0.
2. stall=6'b000000, mem_valid=1, lane0 wd=3 data=0x11, lane1 wd=5 data=0x22, both wreg=1 → one cycle later both enables set, data matches, retired=1.
3. Collision: lane0 and lane1 both wd=7, wreg=1 → wb_wreg=2'b10, wb_wdata lane1=0x22.
4. stall=6'b010000 (STAGE=4) → bubble: all enables 0, wb_wd=0. Then stall=6'b110000 for 3 cycles → outputs hold the bubble; retired unchanged.
5. flush=1 with stall=0 and valid input → bubble captured; next advance with mem_valid=0 and mem_wreg=2'b11 → wb_wreg=0, retired unchanged.
6. Preload retired to 2^CNT_W−1 (CNT_W=4 build: 15 valid advances) → 16th advance wraps retired to 0. With WB_FWD_EN: fwd_raddr port0=5 after test 2 → fwd_hit[0]=1, data 0x22; raddr=0 → no hit.

Source files
------------

// File: rtl/wb_stage_reg_pkg.sv
// wb_stage_reg_pkg: shared constants for the MEM/WB stage register
package wb_stage_reg_pkg;
   localparam int STALL_W = 6;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 32;
   localparam logic [DEF_ADDR_W-1:0] NOP_ADDR = '0;
   localparam logic WE_ON = 1'b1;
   localparam logic WE_OFF = 1'b0;
endpackage

// File: rtl/wb_collide_mask.sv
// wb_collide_mask: drops enables of lanes overwritten by a higher lane at the same address
module wb_collide_mask
   import wb_stage_reg_pkg::*;
#(
   parameter int NUM_LANES = 2,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic [NUM_LANES*ADDR_W-1:0] wd,
   input  logic [NUM_LANES-1:0]        we,
   output logic [NUM_LANES-1:0]        we_masked
);
   // a lane survives only if no later lane writes the same address
   always_comb begin
      we_masked = we;
      for (int i = 0; i < NUM_LANES; i++)
         for (int j = i + 1; j < NUM_LANES; j++)
            if (we[i] && we[j] && wd[i*ADDR_W +: ADDR_W] == wd[j*ADDR_W +: ADDR_W])
               we_masked[i] = WE_OFF;
   end
endmodule

// File: rtl/wb_stage_reg.sv
// wb_stage_reg: multi-lane MEM/WB pipeline register with retire counter; optional forwarding via WB_FWD_EN
module wb_stage_reg
   import wb_stage_reg_pkg::*;
#(
   parameter int NUM_LANES = 2,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int STAGE = 4,
   parameter int CNT_W = 32
) (
   input  logic                        clk,
   input  logic                        clr,
   input  logic [STALL_W-1:0]          stall,
   input  logic                        flush,
   input  logic                        mem_valid,
   input  logic [NUM_LANES*ADDR_W-1:0] mem_wd,
   input  logic [NUM_LANES-1:0]        mem_wreg,
   input  logic [NUM_LANES*DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0]           mem_hi,
   input  logic [DATA_W-1:0]           mem_lo,
   input  logic                        mem_whilo,
   output logic                        wb_valid,
   output logic [NUM_LANES*ADDR_W-1:0] wb_wd,
   output logic [NUM_LANES-1:0]        wb_wreg,
   output logic [NUM_LANES*DATA_W-1:0] wb_wdata,
   output logic [DATA_W-1:0]           wb_hi,
   output logic [DATA_W-1:0]           wb_lo,
   output logic                        wb_whilo,
   output logic [CNT_W-1:0]            retired
`ifdef WB_FWD_EN
   ,
   input  logic [2*ADDR_W-1:0]         fwd_raddr,
   output logic [1:0]                  fwd_hit,
   output logic [2*DATA_W-1:0]         fwd_data
`endif
);
   logic [NUM_LANES-1:0] we_resolved;
   logic bubble, advance;
   logic unused_stall;
   assign unused_stall = ^stall;
   assign bubble = flush || (stall[STAGE] && !stall[STAGE+1]);
   assign advance = !stall[STAGE];
   wb_collide_mask #(.NUM_LANES(NUM_LANES), .ADDR_W(ADDR_W)) u_collide (
      .wd(mem_wd),
      .we(mem_wreg & {NUM_LANES{mem_valid}}),
      .we_masked(we_resolved)
   );
   // stage register: clear, bubble, advance, otherwise hold
   always_ff @(posedge clk) begin
      if (clr || bubble) begin
         wb_valid <= 1'b0;
         wb_wd <= {NUM_LANES{ADDR_W'(NOP_ADDR)}};
         wb_wreg <= {NUM_LANES{WE_OFF}};
         wb_wdata <= '0;
         wb_hi <= '0;
         wb_lo <= '0;
         wb_whilo <= WE_OFF;
         if (clr) retired <= '0;
      end else if (advance) begin
         wb_valid <= mem_valid;
         wb_wd <= mem_wd;
         wb_wreg <= we_resolved;
         wb_wdata <= mem_wdata;
         wb_hi <= mem_hi;
         wb_lo <= mem_lo;
         wb_whilo <= mem_whilo & mem_valid;
         retired <= retired + CNT_W'(mem_valid);
      end
   end
`ifdef WB_FWD_EN
   for (genvar p = 0; p < 2; p++) begin : g_fwd
      logic [ADDR_W-1:0] ra;
      logic [NUM_LANES-1:0] match, sel;
      logic [DATA_W-1:0] d;
      assign ra = fwd_raddr[p*ADDR_W +: ADDR_W];
      // lanes currently writing the requested nonzero address
      always_comb begin
         match = '0;
         for (int i = 0; i < NUM_LANES; i++)
            match[i] = wb_wreg[i] && wb_wd[i*ADDR_W +: ADDR_W] == ra && ra != ADDR_W'(NOP_ADDR);
      end
      wb_collide_mask #(.NUM_LANES(NUM_LANES), .ADDR_W(ADDR_W)) u_pick (
         .wd(wb_wd),
         .we(match),
         .we_masked(sel)
      );
      // one-hot select of the highest matching lane
      always_comb begin
         d = '0;
         for (int i = 0; i < NUM_LANES; i++)
            d = d | (sel[i] ? wb_wdata[i*DATA_W +: DATA_W] : '0);
      end
      assign fwd_hit[p] = |sel;
      assign fwd_data[p*DATA_W +: DATA_W] = d;
   end
`endif
endmodule

// File: tb/tb_wb_stage_reg.sv
// tb_wb_stage_reg: scoreboard bench for wb_stage_reg (2 lanes, 4-bit counter)
module tb_wb_stage_reg;
   typedef struct packed {
      logic        valid;
      logic [9:0]  wd;
      logic [1:0]  wreg;
      logic [63:0] wdata;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        whilo;
      logic [3:0]  retired;
   } out_t;

   logic clk = 1'b0;
   logic clr = 1'b0;
   logic [5:0] stall = '0;
   logic flush = 1'b0;
   logic mem_valid = 1'b0;
   logic [9:0] mem_wd = '0;
   logic [1:0] mem_wreg = '0;
   logic [63:0] mem_wdata = '0;
   logic [31:0] mem_hi = '0;
   logic [31:0] mem_lo = '0;
   logic mem_whilo = 1'b0;
   logic wb_valid;
   logic [9:0] wb_wd;
   logic [1:0] wb_wreg;
   logic [63:0] wb_wdata;
   logic [31:0] wb_hi;
   logic [31:0] wb_lo;
   logic wb_whilo;
   logic [3:0] retired;
`ifdef WB_FWD_EN
   logic [9:0] fwd_raddr = '0;
   logic [1:0] fwd_hit;
   logic [63:0] fwd_data;
`endif

   int tests = 0;
   int fails = 0;
   out_t model = '0;
   out_t sb[$];
   out_t obs, exp_v;

   always #5 clk = ~clk;

   wb_stage_reg #(.NUM_LANES(2), .ADDR_W(5), .DATA_W(32), .STAGE(4), .CNT_W(4)) dut (
      .clk(clk), .clr(clr), .stall(stall), .flush(flush),
      .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
      .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
      .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo), .retired(retired)
`ifdef WB_FWD_EN
      , .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
   );

   assign obs = '{valid: wb_valid, wd: wb_wd, wreg: wb_wreg, wdata: wb_wdata,
                  hi: wb_hi, lo: wb_lo, whilo: wb_whilo, retired: retired};

   function automatic logic [1:0] resolve(input logic [1:0] we, input logic [9:0] wd);
      logic [1:0] r;
      r = we;
      if (we == 2'b11 && wd[4:0] == wd[9:5]) r = 2'b10;
      return r;
   endfunction

   task automatic step(input logic c, input logic f, input logic [5:0] s, input logic v,
                       input logic [9:0] wd, input logic [1:0] we, input logic [63:0] wdata,
                       input logic [31:0] hi, input logic [31:0] lo, input logic whl);
      logic [3:0] r;
      clr = c; flush = f; stall = s; mem_valid = v; mem_wd = wd; mem_wreg = we;
      mem_wdata = wdata; mem_hi = hi; mem_lo = lo; mem_whilo = whl;
      if (c) model = '0;
      else if (f || (s[4] && !s[5])) begin
         r = model.retired;
         model = '0;
         model.retired = r;
      end else if (!s[4]) begin
         model.valid = v;
         model.wd = wd;
         model.wreg = v ? resolve(we, wd) : 2'b00;
         model.wdata = wdata;
         model.hi = hi;
         model.lo = lo;
         model.whilo = whl & v;
         model.retired = model.retired + 4'(v);
      end
      sb.push_back(model);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1, 0, 6'b000000, 1, {5'd9, 5'd8}, 2'b11, 64'h1234_5678_9abc_def0, 32'h1, 32'h2, 1);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL reset got=%h exp=%h", obs, exp_v); end
      step(1, 0, 6'b110000, 1, {5'd9, 5'd8}, 2'b11, 64'h1, 32'h1, 32'h2, 1);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL reset_mid_stall got=%h exp=%h", obs, exp_v); end
   endtask

   task automatic test_advance();
      step(0, 0, 6'b000000, 1, {5'd5, 5'd3}, 2'b11, {32'h22, 32'h11}, 32'hAA, 32'hBB, 1);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v || wb_wreg !== 2'b11 || retired !== 4'd1)
         begin fails++; $display("FAIL advance got=%h exp=%h", obs, exp_v); end
`ifdef WB_FWD_EN
      fwd_raddr = {5'd0, 5'd5};
      #1;
      tests++;
      if (fwd_hit !== 2'b01 || fwd_data[31:0] !== 32'h22 || fwd_data[63:32] !== 32'h0)
         begin fails++; $display("FAIL fwd_lookup got=%b/%h exp=01/0000000000000022", fwd_hit, fwd_data); end
`endif
      step(0, 0, 6'b000000, 1, {5'd0, 5'd4}, 2'b11, {32'h44, 32'h33}, 32'h0, 32'h0, 0);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL advance_addr0 got=%h exp=%h", obs, exp_v); end
   endtask

   task automatic test_collision();
      step(0, 0, 6'b000000, 1, {5'd7, 5'd7}, 2'b11, {32'h22, 32'h11}, 32'h5, 32'h6, 0);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v || wb_wreg !== 2'b10 || wb_wdata[63:32] !== 32'h22)
         begin fails++; $display("FAIL collision got=%h exp=%h", obs, exp_v); end
`ifdef WB_FWD_EN
      fwd_raddr = {5'd7, 5'd7};
      #1;
      tests++;
      if (fwd_hit !== 2'b11 || fwd_data !== {32'h22, 32'h22})
         begin fails++; $display("FAIL fwd_collide got=%b/%h exp=11/0000002200000022", fwd_hit, fwd_data); end
`endif
      step(0, 0, 6'b000000, 1, {5'd0, 5'd0}, 2'b11, {32'h66, 32'h55}, 32'h5, 32'h6, 0);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL collision_addr0 got=%h exp=%h", obs, exp_v); end
   endtask

   task automatic test_stall();
      logic [3:0] r0;
      r0 = model.retired;
      step(0, 0, 6'b010000, 1, {5'd2, 5'd1}, 2'b11, {32'h77, 32'h88}, 32'h9, 32'h9, 1);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL stall_bubble got=%h exp=%h", obs, exp_v); end
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 6'b110000, 1, {5'd2, 5'd1}, 2'b11, {32'h77, 32'h88}, 32'h9, 32'h9, 1);
         exp_v = sb.pop_front();
         tests++;
         if (obs !== exp_v || retired !== r0)
            begin fails++; $display("FAIL stall_hold%0d got=%h exp=%h", k, obs, exp_v); end
      end
      step(0, 0, 6'b001111, 1, {5'd2, 5'd1}, 2'b01, {32'h77, 32'h88}, 32'h9, 32'h8, 1);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL stall_release got=%h exp=%h", obs, exp_v); end
   endtask

   task automatic test_flush();
      step(0, 1, 6'b000000, 1, {5'd6, 5'd4}, 2'b11, {32'h1, 32'h2}, 32'h3, 32'h4, 1);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL flush got=%h exp=%h", obs, exp_v); end
      step(0, 0, 6'b000000, 0, {5'd6, 5'd4}, 2'b11, {32'h1, 32'h2}, 32'h3, 32'h4, 1);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v || wb_wreg !== 2'b00)
         begin fails++; $display("FAIL invalid_advance got=%h exp=%h", obs, exp_v); end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 12; k++) begin
         step(0, 0, 6'b000000, 1'($urandom_range(0, 1)),
              {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))}, 2'($urandom),
              {$urandom, $urandom}, $urandom, $urandom, 1'($urandom));
         exp_v = sb.pop_front();
         tests++;
         if (obs !== exp_v) begin fails++; $display("FAIL b2b%0d got=%h exp=%h", k, obs, exp_v); end
      end
   endtask

   task automatic test_wrap();
      step(1, 0, 6'b000000, 0, '0, '0, '0, '0, '0, 0);
      void'(sb.pop_front());
      for (int k = 1; k <= 16; k++) begin
         step(0, 0, 6'b000000, 1, {5'(k), 5'(k + 1)}, 2'b11, {32'(k), 32'(k * 3)}, 32'(k), 32'(k), 0);
         exp_v = sb.pop_front();
         tests++;
         if (obs !== exp_v || retired !== 4'(k))
            begin fails++; $display("FAIL wrap%0d got=%h exp=%h", k, obs, exp_v); end
      end
   endtask

   initial begin
      test_reset();
      test_advance();
      test_collision();
      test_stall();
      test_flush();
      test_back_to_back();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
